// File: rtl/gemm_exec_ctrl.sv
// gemm_exec_ctrl: compute sequencer between the batch controller and the
// output controller. Walks ROWS output rows, issuing DEPTH source/parameter
// reads per row, drives the MAC accumulate enables RD_LAT cycles later,
// handshakes with the output controller after each row and reports batch
// completion on s_fin.
// Optional build macro GEMM_EXEC_PERF_EN adds a 16-bit saturating busy-cycle
// counter on port perf_cycles.
//
// state    | meaning
// IDLE     | waiting for s_init
// ISSUE    | one read per cycle, k = 0..DEPTH-1 for the current row
// DRAIN    | RD_LAT cycles for the last reads to reach the MACs
// WAIT_OUT | waiting for the output controller to take and finish the row
module gemm_exec_ctrl #(
  parameter int ROWS   = 4,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1,
  parameter int SA_W   = 5,
  parameter int PA_W   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            s_init,
  input  logic            out_busy,
  output logic            rd_en,
  output logic [SA_W-1:0] src_ra,
  output logic [PA_W-1:0] prm_ra,
  output logic            acc_en,
  output logic            acc_first,
  output logic            k_fin,
  output logic            s_fin,
`ifdef GEMM_EXEC_PERF_EN
  output logic [15:0]     perf_cycles,
`endif
  output logic            busy
);

  localparam int K_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_WAIT_OUT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [R_W-1:0]    row_q, row_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              seen_q, seen_d;
  logic              rd_en_q, rd_en_d;
  logic [SA_W-1:0]   src_ra_q, src_ra_d;
  logic [PA_W-1:0]   prm_ra_q, prm_ra_d;
  logic              k_fin_q, k_fin_d;
  logic              s_fin_q, s_fin_d;
  logic              busy_q, busy_d;
  logic [RD_LAT-1:0] acc_pipe_q, acc_pipe_d;
  logic [RD_LAT-1:0] first_pipe_q, first_pipe_d;

  // Sequencer next state; run low overrides everything back to IDLE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    seen_d  = seen_q;
    k_fin_d = 1'b0;
    s_fin_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_init) begin
          state_d = ST_ISSUE;
          row_d   = '0;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (k_q == K_W'(DEPTH - 1)) begin
          k_d     = '0;
          dcnt_d  = 2'(RD_LAT - 1);
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == 2'd0) begin
          k_fin_d = 1'b1;
          state_d = ST_WAIT_OUT;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      ST_WAIT_OUT: begin
        // out_busy seen in the k_fin cycle already counts as the handshake
        if (out_busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d = 1'b0;
          if (row_q == R_W'(ROWS - 1)) begin
            s_fin_d = 1'b1;
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!run) begin
      state_d = ST_IDLE;
      row_d   = '0;
      k_d     = '0;
      dcnt_d  = '0;
      seen_d  = 1'b0;
      k_fin_d = 1'b0;
      s_fin_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet in phase.
  always_comb begin
    rd_en_d      = run && (state_d == ST_ISSUE);
    src_ra_d     = rd_en_d ? SA_W'(int'(row_d) * DEPTH + int'(k_d)) : '0;
    prm_ra_d     = rd_en_d ? PA_W'(k_d) : '0;
    busy_d       = run && ((state_d != ST_IDLE) || s_fin_d);
    acc_pipe_d   = run ? RD_LAT'({acc_pipe_q, rd_en_q}) : '0;
    first_pipe_d = run ? RD_LAT'({first_pipe_q, rd_en_q && (k_q == '0)}) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      k_q          <= '0;
      dcnt_q       <= '0;
      seen_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      src_ra_q     <= '0;
      prm_ra_q     <= '0;
      k_fin_q      <= 1'b0;
      s_fin_q      <= 1'b0;
      busy_q       <= 1'b0;
      acc_pipe_q   <= '0;
      first_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      k_q          <= k_d;
      dcnt_q       <= dcnt_d;
      seen_q       <= seen_d;
      rd_en_q      <= rd_en_d;
      src_ra_q     <= src_ra_d;
      prm_ra_q     <= prm_ra_d;
      k_fin_q      <= k_fin_d;
      s_fin_q      <= s_fin_d;
      busy_q       <= busy_d;
      acc_pipe_q   <= acc_pipe_d;
      first_pipe_q <= first_pipe_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign src_ra    = src_ra_q;
  assign prm_ra    = prm_ra_q;
  assign acc_en    = acc_pipe_q[RD_LAT-1];
  assign acc_first = first_pipe_q[RD_LAT-1];
  assign k_fin     = k_fin_q;
  assign s_fin     = s_fin_q;
  assign busy      = busy_q;

`ifdef GEMM_EXEC_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Busy-cycle counter: cleared on an accepted start, saturating, held when idle.
  always_comb begin
    perf_d = perf_q;
    if (!run) begin
      perf_d = '0;
    end else if ((state_q == ST_IDLE) && s_init) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_gemm_exec_ctrl.sv
// Bench for gemm_exec_ctrl: a default instance and an RD_LAT=3 instance,
// checked cycle by cycle against a timeline built from the row/handshake rules.
module tb_gemm_exec_ctrl;
  localparam int ROWS  = 4;
  localparam int DEPTH = 8;
  localparam int SA_W  = 5;
  localparam int PA_W  = 3;
  localparam int MAXC  = 256;
  localparam int VW    = SA_W + PA_W + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run;
  logic s_init_a, out_busy_a, s_init_b, out_busy_b;
  logic rd_en_a, acc_en_a, acc_first_a, k_fin_a, s_fin_a, busy_a;
  logic rd_en_b, acc_en_b, acc_first_b, k_fin_b, s_fin_b, busy_b;
  logic [SA_W-1:0] src_ra_a, src_ra_b;
  logic [PA_W-1:0] prm_ra_a, prm_ra_b;
`ifdef GEMM_EXEC_PERF_EN
  logic [15:0] perf_a, perf_b;
`endif

  gemm_exec_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .s_init(s_init_a), .out_busy(out_busy_a),
    .rd_en(rd_en_a), .src_ra(src_ra_a), .prm_ra(prm_ra_a), .acc_en(acc_en_a),
    .acc_first(acc_first_a), .k_fin(k_fin_a), .s_fin(s_fin_a),
`ifdef GEMM_EXEC_PERF_EN
    .perf_cycles(perf_a),
`endif
    .busy(busy_a));

  gemm_exec_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .run(run), .s_init(s_init_b), .out_busy(out_busy_b),
    .rd_en(rd_en_b), .src_ra(src_ra_b), .prm_ra(prm_ra_b), .acc_en(acc_en_b),
    .acc_first(acc_first_b), .k_fin(k_fin_b), .s_fin(s_fin_b),
`ifdef GEMM_EXEC_PERF_EN
    .perf_cycles(perf_b),
`endif
    .busy(busy_b));

  // expected timeline and input schedule
  bit e_rd[MAXC], e_acc[MAXC], e_first[MAXC], e_kfin[MAXC], e_sfin[MAXC], e_busy[MAXC];
  int e_src[MAXC];
  bit drv_ob[MAXC], drv_si[MAXC], drv_run[MAXC], acc_si[MAXC];
  int ncyc;
  int gap[ROWS], hi[ROWS];
  int vectors = 0;
  int miscompares = 0;
  int perf_model = 0;

  function automatic logic [VW-1:0] pack(input logic rd, input int src, input int prm,
                                         input logic acc, input logic first,
                                         input logic kf, input logic sf, input logic bz);
    return {rd, SA_W'(src), PA_W'(prm), acc, first, kf, sf, bz};
  endfunction

  // Build the timeline: each row reads for DEPTH cycles, k_fin follows the last
  // accumulate, and the next row starts the cycle after out_busy is seen low
  // having been high since k_fin.
  task automatic plan(input int lat, input int resi_row, input int drop_c);
    int t, kf;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_src[c] = 0; e_acc[c] = 0; e_first[c] = 0;
      e_kfin[c] = 0; e_sfin[c] = 0; e_busy[c] = 0;
      drv_ob[c] = 0; drv_si[c] = 0; drv_run[c] = 1; acc_si[c] = 0;
    end
    drv_si[0] = 1;
    acc_si[0] = 1;
    t = 1;
    for (int r = 0; r < ROWS; r++) begin
      if (r == resi_row) drv_si[t + 2] = 1;
      for (int k = 0; k < DEPTH; k++) begin
        e_rd[t + k]        = 1;
        e_src[t + k]       = r * DEPTH + k;
        e_acc[t + k + lat] = 1;
      end
      e_first[t + lat] = 1;
      kf = t + DEPTH + lat;
      e_kfin[kf] = 1;
      for (int j = 0; j < hi[r]; j++) drv_ob[kf + gap[r] + j] = 1;
      t = kf + gap[r] + hi[r] + 1;
    end
    e_sfin[t] = 1;
    for (int c = 1; c <= t; c++) e_busy[c] = 1;
    ncyc = t + 3;
    if (drop_c >= 0) begin
      drv_run[drop_c] = 0;
      for (int c = drop_c + 1; c < MAXC; c++) begin
        e_rd[c] = 0; e_acc[c] = 0; e_first[c] = 0; e_kfin[c] = 0;
        e_sfin[c] = 0; e_busy[c] = 0; drv_ob[c] = 0; drv_si[c] = 0;
      end
      ncyc = drop_c + 5;
    end
  endtask

  // Apply the schedule to one instance and compare every cycle.
  task automatic run_plan(input int sel, input string tag);
    logic [VW-1:0] obs, expv;
    int kf_obs, kf_exp;
    kf_obs = 0;
    kf_exp = 0;
    for (int c = 0; c < ncyc; c++) begin
      run = drv_run[c];
      if (sel == 0) begin
        s_init_a = drv_si[c]; out_busy_a = drv_ob[c]; s_init_b = 0; out_busy_b = 0;
        obs = pack(rd_en_a, e_rd[c] ? int'(src_ra_a) : 0, e_rd[c] ? int'(prm_ra_a) : 0,
                   acc_en_a, acc_first_a, k_fin_a, s_fin_a, busy_a);
        kf_obs += int'(k_fin_a);
      end else begin
        s_init_b = drv_si[c]; out_busy_b = drv_ob[c]; s_init_a = 0; out_busy_a = 0;
        obs = pack(rd_en_b, e_rd[c] ? int'(src_ra_b) : 0, e_rd[c] ? int'(prm_ra_b) : 0,
                   acc_en_b, acc_first_b, k_fin_b, s_fin_b, busy_b);
        kf_obs += int'(k_fin_b);
      end
      kf_exp += int'(e_kfin[c]);
      expv = pack(e_rd[c], e_rd[c] ? e_src[c] : 0, e_rd[c] ? e_src[c] % DEPTH : 0,
                  e_acc[c], e_first[c], e_kfin[c], e_sfin[c], e_busy[c]);
      vectors++;
      assert (obs === expv) else begin
        miscompares++;
        $error("FAIL %s cyc %0d got %h exp %h (rd,src,prm,acc,first,kfin,sfin,busy)",
               tag, c, obs, expv);
      end
`ifdef GEMM_EXEC_PERF_EN
      if (sel == 0) begin
        vectors++;
        assert (perf_a === 16'(perf_model)) else begin
          miscompares++;
          $error("FAIL %s_perf cyc %0d got %0d exp %0d", tag, c, perf_a, perf_model);
        end
        if (!drv_run[c]) perf_model = 0;
        else if (acc_si[c]) perf_model = 0;
        else if (e_busy[c] && perf_model < 16'hFFFF) perf_model++;
      end
`endif
      @(posedge clk);
      #1;
    end
    vectors++;
    assert (kf_obs === kf_exp) else begin
      miscompares++;
      $error("FAIL %s_kfin_count got %0d exp %0d", tag, kf_obs, kf_exp);
    end
  endtask

  task automatic set_handshake(input int g, input int h);
    for (int r = 0; r < ROWS; r++) begin
      gap[r] = g;
      hi[r]  = h;
    end
  endtask

  initial begin
    logic [VW-1:0] zero_obs;
    reset = 1; run = 1;
    s_init_a = 0; out_busy_a = 0; s_init_b = 0; out_busy_b = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;

    zero_obs = pack(rd_en_a, int'(src_ra_a), int'(prm_ra_a), acc_en_a, acc_first_a,
                    k_fin_a, s_fin_a, busy_a);
    vectors++;
    assert (zero_obs === '0) else begin
      miscompares++;
      $error("FAIL reset_a got %h exp 0", zero_obs);
    end
    zero_obs = pack(rd_en_b, int'(src_ra_b), int'(prm_ra_b), acc_en_b, acc_first_b,
                    k_fin_b, s_fin_b, busy_b);
    vectors++;
    assert (zero_obs === '0) else begin
      miscompares++;
      $error("FAIL reset_b got %h exp 0", zero_obs);
    end

    set_handshake(1, 5);
    plan(1, -1, -1);
    run_plan(0, "basic");

    plan(3, -1, -1);
    run_plan(1, "lat3");

    set_handshake(1, 5);
    hi[1] = 20;
    plan(1, -1, -1);
    run_plan(0, "hold");

    set_handshake(0, 3);
    plan(1, 1, -1);
    run_plan(0, "resinit");

    set_handshake(1, 5);
    plan(1, -1, 5);
    run_plan(0, "rundrop");

    plan(1, -1, -1);
    run_plan(0, "restart");

    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < ROWS; r++) begin
        gap[r] = int'($urandom_range(0, 3));
        hi[r]  = int'($urandom_range(1, 6));
      end
      plan((n % 2 == 0) ? 1 : 3, (n == 2) ? 2 : -1, -1);
      run_plan(n % 2, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
